seq_bit_serializer: RTL

//   Upstream feeder for the serial sequence detectors (e.g. the overlapping Moore 1101 detector).

---
 rtl/seq_pkg.sv | 13 +
 rtl/seq_bit_serializer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence feeder and detector harnesses.
package seq_pkg;

    // Serializer FSM encodings
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Default word width, shared with the detector test harnesses
    localparam int unsigned SEQ_WIDTH = 8;

endpackage : seq_pkg

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder: accepts words over valid/ready and emits one bit
// per enabled clock, with seamless back-to-back words and a stall input.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = SEQ_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    input  logic             shift_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy
);

    localparam int unsigned    CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-2:0] sreg_q, sreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;

    logic             accept;
    logic             load_bit;
    logic [WIDTH-2:0] load_rest;
    logic             next_bit;
    logic [WIDTH-2:0] sreg_shifted;

    // Bit ordering: the shift register always holds the not-yet-sent bits,
    // with the next one to send at the "send end" chosen by MSB_FIRST.
    if (MSB_FIRST) begin : g_msb_first
        assign load_bit     = word_in[WIDTH-1];
        assign load_rest    = word_in[WIDTH-2:0];
        assign next_bit     = sreg_q[WIDTH-2];
        assign sreg_shifted = sreg_q << 1;
    end else begin : g_lsb_first
        assign load_bit     = word_in[0];
        assign load_rest    = word_in[WIDTH-1:1];
        assign next_bit     = sreg_q[0];
        assign sreg_shifted = sreg_q >> 1;
    end

    // Ready in IDLE, or on the last enabled bit of a word so the next word follows without a gap
    assign word_ready = (state_q == IDLE) ||
                        ((state_q == SHIFT) && (cnt_q == '0) && shift_en);
    assign accept     = word_valid && word_ready;

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign busy       = (state_q == SHIFT);

    // Next-state and datapath: load on accept, shift when enabled, hold on stall
    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = bit_valid_q;

        unique case (state_q)
            IDLE: begin
                bit_out_d   = IDLE_BIT;
                bit_valid_d = 1'b0;
                if (accept) begin
                    state_d     = SHIFT;
                    bit_out_d   = load_bit;
                    sreg_d      = load_rest;
                    cnt_d       = CNT_LAST;
                    bit_valid_d = 1'b1;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_q != '0) begin
                        bit_out_d = next_bit;
                        sreg_d    = sreg_shifted;
                        cnt_d     = cnt_q - CW'(1);
                    end else if (accept) begin
                        bit_out_d   = load_bit;
                        sreg_d      = load_rest;
                        cnt_d       = CNT_LAST;
                        bit_valid_d = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        bit_out_d   = IDLE_BIT;
                        bit_valid_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                bit_out_d   = IDLE_BIT;
                bit_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any word in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            bit_out_q   <= IDLE_BIT;
            bit_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
        end
    end

endmodule : seq_bit_serializer
